// File: rtl/mac_cfg_loader_pkg.sv
// Shared widths and FSM encoding for the MAC cluster configuration loader.
// MAC_CFG_PARITY_EN adds one trailing even-parity beat to every load.
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 3
`endif

package mac_cfg_loader_pkg;

  localparam int ACC_W  = `MAC_ACC_WIDTH;
  localparam int CONF_W = `MAC_CONF_WIDTH;

  localparam int IN_W  = 8;
  localparam int CFG_W = 4 * ACC_W + CONF_W;
  localparam int BEATS = (CFG_W + IN_W - 1) / IN_W;

`ifdef MAC_CFG_PARITY_EN
  localparam int NB = BEATS + 1;
`else
  localparam int NB = BEATS;
`endif

  localparam int CNT_W = $clog2(NB + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_APPLY  = 3'd4
  } state_t;

endpackage

// File: rtl/mac_cfg_loader_if.sv
// Beat stream from the chip config port into the loader (valid/ready, LSB-first).
interface mac_cfg_loader_if;
  import mac_cfg_loader_pkg::*;

  logic            s_valid;
  logic            s_ready;
  logic [IN_W-1:0] s_data;
  logic            s_last;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/mac_cfg_loader.sv
// Stages a beat-serial cfg word and commits it atomically while the cluster is idle.
// Build option MAC_CFG_PARITY_EN: expects an extra even-parity beat after the payload.
module mac_cfg_loader
  import mac_cfg_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mac_cfg_loader_if.slave  s,
  input  logic             mac_en,
  output logic [CFG_W-1:0] cfg,
  output logic             cfg_valid,
  output logic             mac_rst,
  output logic             busy,
  output logic             err
);

  state_t             state_q, state_d;
  logic [CFG_W-1:0]   stg_q, stg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic               mac_rst_q, mac_rst_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   wr_idx;
  logic               xfer;
  logic               last_idx;
  logic               par_ok;

  assign s.s_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign xfer      = s.s_valid && s.s_ready;
  assign last_idx  = (cnt_q == CNT_W'(NB - 1));

`ifdef MAC_CFG_PARITY_EN
  assign par_ok = ((^stg_q) == s.s_data[0]);
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    stg_d       = stg_q;
    cnt_d       = cnt_q;
    cfg_d       = cfg_q;
    cfg_valid_d = cfg_valid_q;
    err_d       = err_q;
    wr_idx      = (state_q == ST_IDLE) ? '0 : cnt_q;

    // Payload bits land by beat index; bits of the final beat above CFG_W-1 fall away.
    if (xfer && state_q != ST_DRAIN) begin
      for (int i = 0; i < CFG_W; i++) begin
        if (wr_idx == CNT_W'(i / IN_W)) stg_d[i] = s.s_data[i % IN_W];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          err_d   = 1'b0;
          cnt_d   = CNT_W'(1);
          state_d = (NB == 1 && s.s_last) ? ST_COMMIT : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_idx) begin
            if (!s.s_last) begin
              err_d   = 1'b1;
              state_d = ST_DRAIN;
            end else if (!par_ok) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_COMMIT;
            end
          end else if (s.s_last) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (xfer && s.s_last) state_d = ST_IDLE;
      end
      ST_COMMIT: begin
        if (!mac_en) begin
          cfg_d       = stg_q;
          cfg_valid_d = 1'b1;
          state_d     = ST_APPLY;
        end
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Held high from reset until the first APPLY ends, then high only during APPLY.
    mac_rst_d = (state_d == ST_APPLY) || (mac_rst_q && state_q != ST_APPLY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      // NOTE: the staging store is flops, not a RAM macro, so it resets with everything else.
      stg_q       <= '0;
      cnt_q       <= '0;
      cfg_q       <= '0;
      cfg_valid_q <= 1'b0;
      mac_rst_q   <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      state_q     <= state_d;
      stg_q       <= stg_d;
      cnt_q       <= cnt_d;
      cfg_q       <= cfg_d;
      cfg_valid_q <= cfg_valid_d;
      mac_rst_q   <= mac_rst_d;
      err_q       <= err_d;
    end
  end

  assign cfg       = cfg_q;
  assign cfg_valid = cfg_valid_q;
  assign mac_rst   = mac_rst_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_mac_cfg_loader.sv
// Directed bench for mac_cfg_loader: commit timing, mac_en hold-off, error paths, async reset.
module tb_mac_cfg_loader;

  localparam int CFG_W_TB = 131;
  localparam int BEATS_TB = 17;
`ifdef MAC_CFG_PARITY_EN
  localparam int NB_TB = 18;
`else
  localparam int NB_TB = 17;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mac_en = 1'b0;
  logic [CFG_W_TB-1:0] cfg;
  logic cfg_valid, mac_rst, busy, err;

  always #5 clk = ~clk;

  mac_cfg_loader_if bus ();

  mac_cfg_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s         (bus),
    .mac_en    (mac_en),
    .cfg       (cfg),
    .cfg_valid (cfg_valid),
    .mac_rst   (mac_rst),
    .busy      (busy),
    .err       (err)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] beats [0:31];
  logic [CFG_W_TB-1:0] cur_cfg;
  logic [CFG_W_TB-1:0] new_cfg;

  function automatic logic [CFG_W_TB-1:0] exp_cfg();
    logic [CFG_W_TB-1:0] r;
    for (int i = 0; i < CFG_W_TB; i++) r[i] = beats[i / 8][i % 8];
    return r;
  endfunction

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < BEATS_TB; i++) beats[i] = base + 8'(i);
`ifdef MAC_CFG_PARITY_EN
    beats[BEATS_TB] = {7'b0, ^exp_cfg()};
`endif
  endtask

  // Sends beats[first .. first+n-1]; s_last rides on index last_at. Starts and ends at posedge+1.
  task automatic send_seq(input int first, input int n, input int last_at);
    for (int i = first; i < first + n; i++) begin
      int w;
      bus.s_valid = 1'b1;
      bus.s_data  = beats[i];
      bus.s_last  = (i == last_at);
      w = 0;
      while (!bus.s_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      checks++;
      if (bus.s_ready !== 1'b1) begin
        errors++;
        $display("FAIL beat_accept[%0d]: s_ready got %b, expected 1 within 50 cycles", i, bus.s_ready);
      end
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cfg !== '0) begin errors++; $display("FAIL rst_cfg: got %h, expected 0", cfg); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL rst_cfg_valid: got %b, expected 0", cfg_valid); end
    checks++; if (mac_rst !== 1'b1) begin errors++; $display("FAIL rst_mac_rst: got %b, expected 1", mac_rst); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, expected 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b, expected 1", bus.s_ready); end
    checks++; if (mac_rst !== 1'b1) begin errors++; $display("FAIL rst_mac_rst_held: got %b, expected 1", mac_rst); end
  endtask

  task automatic test_basic_load();
    mac_en = 1'b0;
    fill(8'h00);
    new_cfg = exp_cfg();
    send_seq(0, NB_TB, NB_TB - 1);
    // Cycle after the last beat: waiting in COMMIT, nothing committed yet.
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL t1_ready_commit: got %b, expected 0", bus.s_ready); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_early: got %b, expected 0", cfg_valid); end
    @(posedge clk); #1;
    checks++; if (cfg !== new_cfg) begin errors++; $display("FAIL t1_cfg: got %h, expected %h", cfg, new_cfg); end
    checks++; if (cfg[7:0] !== 8'h00) begin errors++; $display("FAIL t1_cfg_lo: got %h, expected 00", cfg[7:0]); end
    checks++; if (cfg[15:8] !== 8'h01) begin errors++; $display("FAIL t1_cfg_b1: got %h, expected 01", cfg[15:8]); end
    checks++; if (cfg[127:120] !== 8'h0F) begin errors++; $display("FAIL t1_cfg_b15: got %h, expected 0f", cfg[127:120]); end
    checks++; if (cfg[130:128] !== 3'b000) begin errors++; $display("FAIL t1_cfg_mode: got %b, expected 000", cfg[130:128]); end
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL t1_cfg_valid: got %b, expected 1", cfg_valid); end
    checks++; if (mac_rst !== 1'b1) begin errors++; $display("FAIL t1_mac_rst_apply: got %b, expected 1", mac_rst); end
    @(posedge clk); #1;
    checks++; if (mac_rst !== 1'b0) begin errors++; $display("FAIL t1_mac_rst_done: got %b, expected 0", mac_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_done: got %b, expected 0", busy); end
    cur_cfg = new_cfg;
  endtask

  task automatic test_mac_en_hold();
    mac_en = 1'b1;
    fill(8'h5A);
    new_cfg = exp_cfg();
    send_seq(0, NB_TB, NB_TB - 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL t2_ready_hold[%0d]: got %b, expected 0", c, bus.s_ready); end
      checks++; if (cfg !== cur_cfg) begin errors++; $display("FAIL t2_cfg_hold[%0d]: got %h, expected %h", c, cfg, cur_cfg); end
      checks++; if (mac_rst !== 1'b0) begin errors++; $display("FAIL t2_mac_rst_hold[%0d]: got %b, expected 0", c, mac_rst); end
    end
    mac_en = 1'b0;
    @(posedge clk); #1;
    checks++; if (cfg !== new_cfg) begin errors++; $display("FAIL t2_cfg: got %h, expected %h", cfg, new_cfg); end
    checks++; if (cfg[7:0] !== 8'h5A) begin errors++; $display("FAIL t2_cfg_lo: got %h, expected 5a", cfg[7:0]); end
    checks++; if (cfg[130:128] !== 3'b010) begin errors++; $display("FAIL t2_cfg_mode: got %b, expected 010", cfg[130:128]); end
    checks++; if (mac_rst !== 1'b1) begin errors++; $display("FAIL t2_mac_rst_apply: got %b, expected 1", mac_rst); end
    @(posedge clk); #1;
    checks++; if (mac_rst !== 1'b0) begin errors++; $display("FAIL t2_mac_rst_done: got %b, expected 0", mac_rst); end
    cur_cfg = new_cfg;
  endtask

  task automatic test_short_load();
    fill(8'hF0);
    send_seq(0, 10, 9);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL t3_err: got %b, expected 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_busy: got %b, expected 0", busy); end
    checks++; if (cfg !== cur_cfg) begin errors++; $display("FAIL t3_cfg_kept: got %h, expected %h", cfg, cur_cfg); end
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL t3_valid_kept: got %b, expected 1", cfg_valid); end
    fill(8'h80);
    new_cfg = exp_cfg();
    send_seq(0, 1, -1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL t3_err_clear: got %b, expected 0", err); end
    send_seq(1, NB_TB - 1, NB_TB - 1);
    @(posedge clk); #1;
    checks++; if (cfg !== new_cfg) begin errors++; $display("FAIL t3_cfg_new: got %h, expected %h", cfg, new_cfg); end
    checks++; if (cfg[7:0] !== 8'h80) begin errors++; $display("FAIL t3_cfg_lo: got %h, expected 80", cfg[7:0]); end
    @(posedge clk); #1;
    cur_cfg = new_cfg;
  endtask

  task automatic test_drain();
    fill(8'h20);
    beats[NB_TB]     = 8'hE1;
    beats[NB_TB + 1] = 8'hE2;
    beats[NB_TB + 2] = 8'hE3;
    send_seq(0, NB_TB, -1);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL t4_err: got %b, expected 1", err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t4_busy_drain: got %b, expected 1", busy); end
    send_seq(NB_TB, 2, -1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t4_busy_drain2: got %b, expected 1", busy); end
    send_seq(NB_TB + 2, 1, NB_TB + 2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_busy_done: got %b, expected 0", busy); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL t4_err_sticky: got %b, expected 1", err); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cfg !== cur_cfg) begin errors++; $display("FAIL t4_cfg_kept: got %h, expected %h", cfg, cur_cfg); end
    checks++; if (mac_rst !== 1'b0) begin errors++; $display("FAIL t4_no_apply: got %b, expected 0", mac_rst); end
  endtask

  task automatic test_async_reset();
    fill(8'h11);
    send_seq(0, 8, -1);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (cfg !== '0) begin errors++; $display("FAIL t5_cfg: got %h, expected 0", cfg); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL t5_cfg_valid: got %b, expected 0", cfg_valid); end
    checks++; if (mac_rst !== 1'b1) begin errors++; $display("FAIL t5_mac_rst: got %b, expected 1", mac_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy: got %b, expected 0", busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL t5_ready_after: got %b, expected 1", bus.s_ready); end
    checks++; if (cfg !== '0) begin errors++; $display("FAIL t5_cfg_after: got %h, expected 0", cfg); end
  endtask

`ifdef MAC_CFG_PARITY_EN
  task automatic test_parity();
    for (int i = 0; i < BEATS_TB; i++) beats[i] = 8'hFF;
    beats[BEATS_TB] = 8'h00;
    send_seq(0, NB_TB, NB_TB - 1);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL t6_err_bad: got %b, expected 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy_bad: got %b, expected 0", busy); end
    @(posedge clk); #1;
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL t6_no_commit: got %b, expected 0", cfg_valid); end
    beats[BEATS_TB] = 8'h01;
    send_seq(0, NB_TB, NB_TB - 1);
    @(posedge clk); #1;
    checks++; if (cfg !== {CFG_W_TB{1'b1}}) begin errors++; $display("FAIL t6_cfg: got %h, expected all ones", cfg); end
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL t6_valid: got %b, expected 1", cfg_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL t6_err_good: got %b, expected 0", err); end
  endtask
`endif

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    cur_cfg     = '0;
    test_reset();
    test_basic_load();
    test_mac_en_hold();
    test_short_load();
    test_drain();
    test_async_reset();
`ifdef MAC_CFG_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
